// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector family.
// Holds the two-state encoding and the cfg_len width helper.
package seq_det_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SEARCH = 1'b1
  } state_e;

  // Wide enough to hold every legal length 1..patW, plus room to see illegal ones.
  function automatic int lenWidth(input int patW);
    return $clog2(patW) + 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a clear input that wins over increment.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Detects a runtime-programmable serial bit pattern on a qualified stream,
// with overlap/non-overlap modes, a registered detect pulse and a match counter.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = lenWidth(PAT_W),
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             din_valid_i,
  input  logic             din_i,
  input  logic             cfg_load_i,
  input  logic [PAT_W-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  input  logic             cfg_overlap_i,
  input  logic             count_clr_i,
  output logic             detected_o,
  output logic [CNT_W-1:0] match_count_o,
  output logic             cfg_err_o,
  output logic             armed_o
);

  state_e             state_q;
  logic [PAT_W-1:0]   history_q;
  logic [PAT_W-1:0]   history_d;
  logic [LEN_W-1:0]   fill_q;
  logic [LEN_W-1:0]   fill_d;
  logic [PAT_W-1:0]   pattern_q;
  logic [LEN_W-1:0]   patLen_q;
  logic               overlap_q;
  logic               detected_q;
  logic               cfgErr_q;

  logic               accept;
  logic               lenLegal;
  logic               matchHit;
  logic [PAT_W-1:0]   lenMask;

  // A bit arriving together with cfg_load is dropped, so config always wins.
  assign accept   = (state_q == ST_SEARCH) && din_valid_i && !cfg_load_i;
  assign lenLegal = (cfg_len_i != '0) && (cfg_len_i <= LEN_W'(PAT_W));

  always_comb begin
    history_d = {history_q[PAT_W-2:0], din_i};
    fill_d    = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
    for (int i = 0; i < PAT_W; i++) begin
      lenMask[i] = (i < int'(patLen_q));
    end
    matchHit = accept && (fill_d >= patLen_q) &&
               (((history_d ^ pattern_q) & lenMask) == '0);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      history_q  <= '0;
      fill_q     <= '0;
      pattern_q  <= '0;
      patLen_q   <= '0;
      overlap_q  <= 1'b0;
      detected_q <= 1'b0;
      cfgErr_q   <= 1'b0;
    end else begin
      detected_q <= matchHit;
      if (cfg_load_i) begin
        if (lenLegal) begin
          state_q   <= ST_SEARCH;
          cfgErr_q  <= 1'b0;
          pattern_q <= cfg_pattern_i;
          patLen_q  <= cfg_len_i;
          overlap_q <= cfg_overlap_i;
          history_q <= '0;
          fill_q    <= '0;
        end else begin
          state_q  <= ST_IDLE;
          cfgErr_q <= 1'b1;
        end
      end else if (accept) begin
        // Non-overlap keeps the history but demands a full set of fresh bits.
        history_q <= history_d;
        fill_q    <= (matchHit && !overlap_q) ? '0 : fill_d;
      end
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_match_cnt (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .inc_i    (matchHit),
    .clr_i    (count_clr_i),
    .count_o  (match_count_o)
  );

  assign detected_o = detected_q;
  assign cfg_err_o  = cfgErr_q;
  assign armed_o    = (state_q == ST_SEARCH);

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench: directed scenarios plus random traffic against a
// bit-queue reference model of the pattern detector.
module tb_seq_pattern_detector;

  localparam int PAT_W   = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n_i;
  logic             din_valid_i;
  logic             din_i;
  logic             cfg_load_i;
  logic [PAT_W-1:0] cfg_pattern_i;
  logic [LEN_W-1:0] cfg_len_i;
  logic             cfg_overlap_i;
  logic             count_clr_i;
  logic             detected_o;
  logic [CNT_W-1:0] match_count_o;
  logic             cfg_err_o;
  logic             armed_o;

  int assertCount = 0;
  int failCount   = 0;

  bit               mArmed;
  bit               mErr;
  bit               mDet;
  bit               mOvl;
  int               mLen;
  int               mCount;
  logic [PAT_W-1:0] mPat;
  bit               hist[$];

  always #5 clk = ~clk;

  seq_pattern_detector #(
    .PAT_W(PAT_W),
    .LEN_W(LEN_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n_i),
    .din_valid_i  (din_valid_i),
    .din_i        (din_i),
    .cfg_load_i   (cfg_load_i),
    .cfg_pattern_i(cfg_pattern_i),
    .cfg_len_i    (cfg_len_i),
    .cfg_overlap_i(cfg_overlap_i),
    .count_clr_i  (count_clr_i),
    .detected_o   (detected_o),
    .match_count_o(match_count_o),
    .cfg_err_o    (cfg_err_o),
    .armed_o      (armed_o)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference: the accepted bits since the last clear are kept as a list;
  // a match means the newest len bits spell the pattern, first bit = pattern[len-1].
  task automatic modelEdge(input bit rstn, input bit load, input logic [PAT_W-1:0] pat,
                           input int len, input bit ovl, input bit valid, input bit d,
                           input bit clr);
    bit hit;
    hit = 1'b0;
    if (!rstn) begin
      mArmed = 0; mErr = 0; mDet = 0; mOvl = 0;
      mLen = 0; mCount = 0; mPat = '0;
      hist.delete();
      return;
    end
    mDet = 0;
    if (load) begin
      if (len >= 1 && len <= PAT_W) begin
        mArmed = 1; mErr = 0; mPat = pat; mLen = len; mOvl = ovl;
        hist.delete();
      end else begin
        mArmed = 0; mErr = 1;
      end
    end else if (mArmed && valid) begin
      hist.push_back(d);
      if (hist.size() > PAT_W) void'(hist.pop_front());
      if (hist.size() >= mLen) begin
        hit = 1'b1;
        for (int k = 0; k < mLen; k++) begin
          if (hist[hist.size() - 1 - k] != mPat[k]) hit = 1'b0;
        end
      end
      if (hit) begin
        mDet = 1;
        if (!mOvl) hist.delete();
      end
    end
    if (clr) mCount = 0;
    else if (hit && mCount < CNT_MAX) mCount++;
  endtask

  task automatic applyStimulus(input bit rstn, input bit load, input logic [PAT_W-1:0] pat,
                               input int len, input bit ovl, input bit valid, input bit d,
                               input bit clr);
    reset_n_i     = rstn;
    cfg_load_i    = load;
    cfg_pattern_i = pat;
    cfg_len_i     = LEN_W'(len);
    cfg_overlap_i = ovl;
    din_valid_i   = valid;
    din_i         = d;
    count_clr_i   = clr;
    @(posedge clk);
    modelEdge(rstn, load, pat, len & ((1 << LEN_W) - 1), ovl, valid, d, clr);
    #1;
    checkOutput("detected", int'(detected_o), int'(mDet));
    checkOutput("match_count", int'(match_count_o), mCount);
    checkOutput("cfg_err", int'(cfg_err_o), int'(mErr));
    checkOutput("armed", int'(armed_o), int'(mArmed));
  endtask

  task automatic doReset();
    applyStimulus(0, 0, '0, 0, 0, 0, 0, 0);
  endtask

  task automatic loadCfg(input logic [PAT_W-1:0] pat, input int len, input bit ovl);
    applyStimulus(1, 1, pat, len, ovl, 0, 0, 0);
  endtask

  task automatic sendBit(input bit valid, input bit d);
    applyStimulus(1, 0, '0, 0, 0, valid, d, 0);
  endtask

  task automatic sendStream(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) sendBit(1, bits[i]);
  endtask

  initial begin
    bit rstn, load, ovl, valid, d, clr;
    int len;
    logic [PAT_W-1:0] pat;

    $display("[TB] starting seq_pattern_detector bench");
    doReset();
    doReset();
    checkOutput("reset_count", int'(match_count_o), 0);
    checkOutput("reset_armed", int'(armed_o), 0);

    // Run-of-ones detector in overlap mode.
    loadCfg(8'b111, 3, 1);
    sendStream(16'b11110, 5);
    checkOutput("ones_count", int'(match_count_o), 2);

    // 1011 on 1011011, non-overlap then overlap.
    loadCfg(8'b1011, 4, 0);
    applyStimulus(1, 0, '0, 0, 0, 0, 0, 1);
    sendStream(16'b1011011, 7);
    checkOutput("nonovl_count", int'(match_count_o), 1);
    loadCfg(8'b1011, 4, 1);
    applyStimulus(1, 0, '0, 0, 0, 0, 0, 1);
    sendStream(16'b1011011, 7);
    checkOutput("ovl_count", int'(match_count_o), 2);

    // Illegal lengths, then a legal one.
    loadCfg(8'b1, 0, 1);
    checkOutput("len0_err", int'(cfg_err_o), 1);
    sendStream(16'b1111, 4);
    loadCfg(8'b1, 9, 1);
    checkOutput("len9_armed", int'(armed_o), 0);
    sendStream(16'b1111, 4);
    loadCfg(8'b11, 2, 1);
    checkOutput("len2_err", int'(cfg_err_o), 0);
    checkOutput("len2_armed", int'(armed_o), 1);

    // Valid qualifier: invalid bits carry the wrong value on purpose.
    loadCfg(8'b101, 3, 0);
    sendBit(1, 1); sendBit(0, 1); sendBit(1, 0); sendBit(0, 0); sendBit(1, 1);
    checkOutput("valid_det", int'(detected_o), 1);
    sendBit(0, 0);

    // Saturation, then clear on a match edge.
    loadCfg(8'b1, 1, 1);
    applyStimulus(1, 0, '0, 0, 0, 0, 0, 1);
    sendStream(16'b111111, 6);
    checkOutput("sat_count", int'(match_count_o), CNT_MAX);
    applyStimulus(1, 0, '0, 0, 0, 1, 1, 1);
    checkOutput("clr_det", int'(detected_o), 1);
    checkOutput("clr_count", int'(match_count_o), 0);

    // Bit presented with a config load is discarded.
    applyStimulus(1, 1, 8'b1, 1, 1, 1, 1, 0);
    checkOutput("load_drop_det", int'(detected_o), 0);

    // Reset mid-pattern, then reload.
    loadCfg(8'b111, 3, 1);
    sendStream(16'b11, 2);
    doReset();
    sendStream(16'b1, 1);
    loadCfg(8'b111, 3, 1);
    sendBit(1, 1);
    checkOutput("post_reset_det", int'(detected_o), 0);
    sendStream(16'b11, 2);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      rstn  = ($urandom_range(0, 149) != 0);
      load  = ($urandom_range(0, 24) == 0);
      pat   = PAT_W'($urandom);
      ovl   = $urandom_range(0, 1);
      case ($urandom_range(0, 9))
        0:       len = $urandom_range(0, 15);
        1, 2:    len = $urandom_range(1, PAT_W);
        default: len = $urandom_range(1, 3);
      endcase
      valid = ($urandom_range(0, 3) != 0);
      d     = $urandom_range(0, 1);
      clr   = ($urandom_range(0, 19) == 0);
      applyStimulus(rstn, load, pat, len, ovl, valid, d, clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
- Parametrised successor to the fixed three-ones run detector.
- Detects a runtime-programmable serial bit pattern of length 1..PAT_W on a qualified 1-bit stream.
- Supports overlapping and non-overlapping match modes, a registered detect pulse and a saturating match counter.
- Sits in the FSM assignment set as the generic serial-stream detector the earlier fixed-pattern FSMs collapse into.

Parameters:
- PAT_W, 8, maximum pattern length in bits (>=2).
- LEN_W, $clog2(PAT_W)+1, width of cfg_len.
- CNT_W, 8, width of match_count.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset.
- din_valid  in  1  din qualifier; bit accepted on an edge where din_valid=1.
- din  in  1  serial data bit.
- cfg_load  in  1  latch cfg_pattern/cfg_len/cfg_overlap this edge.
- cfg_pattern  in  PAT_W  pattern; bit [cfg_len-1] is first-received, bit [0] last-received.
- cfg_len  in  LEN_W  pattern length; legal 1..PAT_W.
- cfg_overlap  in  1  1=overlapping matches, 0=non-overlapping.
- count_clr  in  1  clear match_count.
- detected  out  1  registered one-cycle match pulse.
- match_count  out  CNT_W  saturating count of matches.
- cfg_err  out  1  last cfg_load had illegal cfg_len.
- armed  out  1  block is in SEARCH state.

Behaviour:
- Reset (reset_n=0 at edge): state=IDLE, history=0, fill=0, pattern regs=0, detected=0, match_count=0, cfg_err=0, armed=0. Reset overrides every other input.
- State machine is two states:
  - IDLE: din ignored. On cfg_load with 1<=cfg_len<=PAT_W, go to SEARCH and set cfg_err=0. On cfg_load with an illegal length (0 or >PAT_W), stay in IDLE and set cfg_err=1.
  - SEARCH: on an accepted bit, history <= {history[PAT_W-2:0], din} and fill <= min(fill+1, PAT_W).
- Match condition is evaluated on the post-shift history and fill:
  - fill >= len, and
  - history[len-1:0] == pattern[len-1:0].
- Latency: detected=1 in the cycle after the edge that accepted the completing bit; high for exactly one cycle per match. No bit accepted means detected=0.
- Overlap mode: history and fill are kept after a match. Pattern 11 on stream 111 gives two pulses; the all-ones pattern gives a pulse on every further 1, matching the old run-detector behaviour.
- Non-overlap mode: fill is cleared to 0 on the match edge, so the next match needs len fresh bits.
- Zero bits (din=0) are data, not a reset of the search.
- cfg_load while in SEARCH:
  - Legal length: reload the config, clear history and fill, stay in SEARCH.
  - Illegal length: go to IDLE and set cfg_err=1.
  - A bit presented on the same edge is discarded; detected=0 next cycle.
  - match_count is unaffected by cfg_load.
- match_count increments on each match edge and saturates at 2^CNT_W-1 with no wrap. count_clr sets it to 0. If count_clr and a match occur on the same edge, the count becomes 0 (clear wins) but detected still pulses.
- Pattern bits above len are don't-care.
- armed=1 exactly when state=SEARCH.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package seq_det_pkg: state encoding localparams (ST_IDLE=1'b0, ST_SEARCH=1'b1) and a LEN_W helper function.
- One natural sub-module: sat_counter (CNT_W, inc, clr, clr-priority, saturate). It is reused by later counting blocks.
- Shift/compare logic stays inline in this module.

Test Plan:
- Reset, then load len=3, pattern=3'b111, overlap=1; stream 1,1,1,1,0 -> detected pulses after the 3rd and 4th bits; match_count=2.
- Load len=4, pattern=4'b1011, overlap=0; stream 1011011 -> one pulse after bit 4; bits 5-7 do not match; with overlap=1 on the same stream -> pulses after bits 4 and 7.
- Load len=0, then len=9 (PAT_W=8) -> cfg_err=1, armed=0, no pulses on any stream; then load len=2 -> cfg_err=0, armed=1.
- With din_valid toggling 1,0,1,0,1 on pattern 3'b101 -> din ignored while invalid; single pulse one cycle after the 3rd valid bit.
- CNT_W=2, all-ones pattern len=1, overlap=1, six 1s -> match_count 1,2,3,3,3,3; count_clr asserted on a match edge -> count=0 and detected=1 that cycle.
- reset_n=0 mid-pattern (after 2 of 3 bits), then reload the same config -> count=0, armed=0 until the reload; the partial history is not matched after the reload.
